// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: size encodings, the
// controller state set and small decode helpers.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Number of byte transfers needed for an access size (0 for reserved).
    function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
        case (size)
            SIZE_BYTE: bytes_for_size = 3'd1;
            SIZE_HALF: bytes_for_size = 3'd2;
            SIZE_WORD: bytes_for_size = 3'd4;
            default:   bytes_for_size = 3'd0;
        endcase
    endfunction

    // Reserved size is folded into the misalignment error.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            SIZE_WORD: is_misaligned = addr_lo[1] | addr_lo[0];
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of an assembled load value according to access size.
// Purely combinational so it can also sit behind the WB debug monitor.
module load_extender
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw_data_i,
    input  logic [1:0]  size_i,
    input  logic        se_i,
    output logic [31:0] ext_data_o
);

    // Replicate the access's top bit (or zero) above the loaded field.
    always_comb begin
        ext_data_o = raw_data_i;
        case (size_i)
            SIZE_BYTE: ext_data_o = {{24{se_i & raw_data_i[7]}}, raw_data_i[7:0]};
            SIZE_HALF: ext_data_o = {{16{se_i & raw_data_i[15]}}, raw_data_i[15:0]};
            default:   ext_data_o = raw_data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage controller: turns one latched load/store request into a
// byte-serial sequence on a synchronous-read 8-bit RAM, stalling the
// pipeline until a single-cycle done pulse presents the result.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  req_valid,
    input  logic                  RAM_Enable,
    input  logic                  RAM_RW,
    input  logic [1:0]            RAM_Size,
    input  logic                  RAM_SE,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic [7:0]            ram_rdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned
);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;

    // Request fields captured at accept; inputs are ignored afterwards.
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  rw_q;
    logic                  se_q;

    logic                  accept;
    logic [2:0]            n_bytes;
    logic                  last_byte;
    logic                  cap_en;
    logic [1:0]            cap_lane;
    logic [DATA_WIDTH-1:0] ext_data;

    assign accept    = (state_q == IDLE) && req_valid && RAM_Enable;
    assign n_bytes   = bytes_for_size(size_q);
    assign last_byte = (cnt_q == (n_bytes - 3'd1));

    load_extender u_load_extender (
        .raw_data_i (asm_q),
        .size_i     (size_q),
        .se_i       (se_q),
        .ext_data_o (ext_data)
    );

    // State, counter, assembly register and latched request fields.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            mis_q   <= 1'b0;
            asm_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            asm_q   <= asm_d;
            if (accept) begin
                base_q  <= address;
                wdata_q <= store_data;
                size_q  <= RAM_Size;
                rw_q    <= RAM_RW;
                se_q    <= RAM_SE;
            end
        end
    end

    // Next-state logic and all stage outputs; RAM outputs idle at zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        cap_en     = 1'b0;
        cap_lane   = 2'd0;
        ram_addr   = '0;
        ram_wdata  = 8'd0;
        ram_we     = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        load_data  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    cnt_d = 3'd0;
                    mis_d = is_misaligned(RAM_Size, address[1:0]);
                    state_d = mis_d ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                stall    = 1'b1;
                ram_addr = base_q + ADDR_WIDTH'(cnt_q);
                if (rw_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                end else if (cnt_q != 3'd0) begin
                    // Read data for the previous issue arrives this cycle.
                    cap_en   = 1'b1;
                    cap_lane = 2'(cnt_q - 3'd1);
                end
                cnt_d = cnt_q + 3'd1;
                if (last_byte) begin
                    state_d = rw_q ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                stall    = 1'b1;
                cap_en   = 1'b1;
                cap_lane = 2'(cnt_q - 3'd1);
                state_d  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                misaligned = mis_q;
                if (!mis_q && !rw_q) begin
                    load_data = ext_data;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load assembly: clear on accept, drop each returned byte into its lane.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d = '0;
        end
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (cap_en && (cap_lane == 2'(i))) begin
                asm_d[i*8 +: 8] = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a behavioural RAM and a
// transaction-level reference model of expected per-cycle behaviour.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid, RAM_Enable, RAM_RW, RAM_SE;
    logic [1:0]  RAM_Size;
    logic [8:0]  address;
    logic [31:0] store_data;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we, stall, done, misaligned;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .RAM_Enable (RAM_Enable),
        .RAM_RW     (RAM_RW),
        .RAM_Size   (RAM_Size),
        .RAM_SE     (RAM_SE),
        .address    (address),
        .store_data (store_data),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .stall      (stall),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Synchronous-read data RAM; filled with a known pattern at start.
    logic [7:0] mem [0:511];
    logic       mem_fill;
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i * 37 + 11);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Reference RAM contents as the model believes them to be.
    logic [7:0] ref_mem [0:511];

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle expectations produced by the model.
    bit          chk_en = 1'b0;
    bit          exp_stall, exp_we, exp_done, exp_mis, exp_acc, exp_chk_ld;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [31:0] exp_ld;

    // Single compare process, sampling away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("ram_we", 32'(ram_we), 32'(exp_we));
            check("done", 32'(done), 32'(exp_done));
            check("misaligned", 32'(misaligned), 32'(exp_mis));
            if (exp_acc) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
            if (exp_we) check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
            if (exp_chk_ld) check("load_data", load_data, exp_ld);
        end
    end

    // Drive one request starting at the current cycle and model it to done.
    // rst_cyc >= 0 asserts Reset in that cycle and abandons the request.
    task automatic run_req(input bit v, input bit en, input bit rw,
                           input logic [1:0] sz, input bit se,
                           input logic [8:0] a, input logic [31:0] d,
                           input int rst_cyc,
                           output logic [31:0] got_ld, output bit got_mis);
        int          n, dc, ev;
        bit          acc, mis, rst_hit;
        logic [31:0] raw, ld_model, tmp;
        logic [8:0]  idx;
        got_ld  = '0;
        got_mis = 1'b0;
        rst_hit = 1'b0;
        acc = v && en;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        mis = acc && ((sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
        dc  = !acc ? 0 : mis ? 1 : rw ? n + 1 : n + 2;
        raw = '0;
        for (int i = 0; i < n; i++) begin
            idx = a + 9'(i);
            raw = raw | (32'(ref_mem[idx]) << (8 * i));
        end
        if (sz == 2'd0) begin
            ev = int'(raw[7:0]);
            if (se && ev >= 128) ev = ev - 256;
        end else if (sz == 2'd1) begin
            ev = int'(raw[15:0]);
            if (se && ev >= 32768) ev = ev - 65536;
        end else begin
            ev = int'(raw);
        end
        ld_model = mis ? 32'd0 : 32'(ev);

        req_valid = v; RAM_Enable = en; RAM_RW = rw; RAM_Size = sz;
        RAM_SE = se; address = a; store_data = d;
        for (int c = 0; c <= dc; c++) begin
            if (c > 0) begin
                address    = 9'($urandom);
                store_data = $urandom;
                RAM_Size   = 2'($urandom);
                RAM_RW     = 1'($urandom);
                RAM_SE     = 1'($urandom);
            end
            if (c == rst_cyc) Reset = 1'b1;
            exp_stall  = acc && (c < dc);
            exp_done   = acc && (c == dc);
            exp_acc    = acc && !mis && (c >= 1) && (c <= n);
            exp_we     = exp_acc && rw;
            exp_addr   = a + 9'(c - 1);
            tmp        = d >> (8 * (c - 1));
            exp_wdata  = tmp[7:0];
            exp_mis    = exp_done && mis;
            exp_chk_ld = exp_done && (mis || !rw);
            exp_ld     = ld_model;
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            chk_en = 1'b1;
            @(negedge clk);
            if (c == dc) begin
                got_ld  = load_data;
                got_mis = misaligned;
            end
            @(posedge clk);
            #1;
            if (c == rst_cyc) begin
                rst_hit = 1'b1;
                break;
            end
        end
        if (rst_hit) begin
            Reset = 1'b0; req_valid = 1'b0; RAM_Enable = 1'b0;
            exp_stall = 0; exp_done = 0; exp_acc = 0; exp_we = 0;
            exp_mis = 0; exp_chk_ld = 0;
            @(negedge clk);
            check("post_reset_ram_addr", 32'(ram_addr), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] ld;
    bit          mf;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; mem_fill = 1'b1;
        req_valid = 0; RAM_Enable = 0; RAM_RW = 0; RAM_Size = 0; RAM_SE = 0;
        address = '0; store_data = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 37 + 11);
        @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_ld", load_data, 32'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0; mem_fill = 1'b0;

        // Word store then byte/half loads of the stored value.
        run_req(1, 1, 1, 2'b10, 0, 9'h010, 32'hDEADBEEF, -1, ld, mf);
        run_req(1, 1, 0, 2'b00, 1, 9'h012, 32'h0, -1, ld, mf);
        check("lb_signed", ld, 32'hFFFFFFAD);
        run_req(1, 1, 0, 2'b00, 0, 9'h012, 32'h0, -1, ld, mf);
        check("lb_unsigned", ld, 32'h000000AD);
        run_req(1, 1, 0, 2'b01, 0, 9'h010, 32'h0, -1, ld, mf);
        check("lh_unsigned", ld, 32'h0000BEEF);
        run_req(1, 1, 0, 2'b01, 1, 9'h010, 32'h0, -1, ld, mf);
        check("lh_signed", ld, 32'hFFFFBEEF);

        // Misaligned word and reserved size.
        run_req(1, 1, 0, 2'b10, 0, 9'h011, 32'h0, -1, ld, mf);
        check("mis_word_flag", 32'(mf), 32'd1);
        check("mis_word_ld", ld, 32'd0);
        run_req(1, 1, 1, 2'b11, 0, 9'h010, 32'h12345678, -1, ld, mf);
        check("mis_rsvd_flag", 32'(mf), 32'd1);
        run_req(1, 1, 1, 2'b01, 0, 9'h013, 32'h0000CAFE, -1, ld, mf);
        check("mis_half_flag", 32'(mf), 32'd1);

        // Reset in cycle 2 of a word store to 0x020.
        run_req(1, 1, 1, 2'b10, 0, 9'h020, 32'h11223344, 2, ld, mf);
        check("rst_mem20", 32'(mem[9'h020]), 32'h44);
        check("rst_mem21", 32'(mem[9'h021]), 32'h33);
        check("rst_mem22", 32'(mem[9'h022]), 32'hF5);
        check("rst_mem23", 32'(mem[9'h023]), 32'h1A);
        run_req(1, 1, 0, 2'b10, 0, 9'h020, 32'h0, -1, ld, mf);
        check("lw_after_rst", ld, 32'h1AF53344);

        // ADD, word load, byte store back to back.
        run_req(1, 0, 0, 2'b10, 0, 9'h010, 32'h0, -1, ld, mf);
        run_req(1, 1, 0, 2'b10, 1, 9'h010, 32'h0, -1, ld, mf);
        check("lw_b2b", ld, 32'hDEADBEEF);
        run_req(1, 1, 1, 2'b00, 0, 9'h013, 32'hFFFFFF5A, -1, ld, mf);
        run_req(0, 1, 0, 2'b00, 0, 9'h013, 32'h0, -1, ld, mf);
        run_req(1, 1, 0, 2'b00, 1, 9'h013, 32'h0, -1, ld, mf);
        check("lb_after_sb", ld, 32'h0000005A);

        // Top of the address space.
        run_req(1, 1, 1, 2'b01, 0, 9'h1FE, 32'h00008001, -1, ld, mf);
        run_req(1, 1, 0, 2'b01, 1, 9'h1FE, 32'h0, -1, ld, mf);
        check("lh_top_signed", ld, 32'hFFFF8001);
        run_req(1, 1, 0, 2'b00, 0, 9'h1FF, 32'h0, -1, ld, mf);
        check("lb_top_unsigned", ld, 32'h00000080);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
